// File: rtl/rand_vec_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rand_vec_gen_pkg
//  Description : Shared constants, types and helpers for the random latent
//                vector generator: default sample format, xorshift32 shift
//                amounts, lane seed stride, FSM and mode encodings.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package rand_vec_gen_pkg;

    localparam int c_n_len_dflt = 16;
    localparam int c_f_len_dflt = 14;
    localparam int c_i_len_dflt = c_n_len_dflt - c_f_len_dflt;

    // xorshift32 shift amounts
    localparam int c_xs_sh_a = 13;
    localparam int c_xs_sh_b = 17;
    localparam int c_xs_sh_c = 5;

    // Golden-ratio stride keeps the lane seeds far apart in state space
    localparam logic [31:0] c_lane_stride = 32'h9E37_79B9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GEN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MODE_SU     = 2'd0,  // signed uniform
        MODE_UU     = 2'd1,  // unsigned uniform
        MODE_TRI    = 2'd2,  // triangular
        MODE_SU_ALT = 2'd3   // alias of signed uniform
    } mode_t;

    // Seed of lane k; xorshift32 locks up at zero, so zero maps to one.
    function automatic logic [31:0] lane_seed(input logic [31:0] base, input int unsigned k);
        logic [31:0] s;
        s = base + (32'(k) * c_lane_stride);
        return (s == 32'd0) ? 32'd1 : s;
    endfunction

    function automatic logic [31:0] xs32_step(input logic [31:0] x);
        logic [31:0] t;
        t = x ^ (x << c_xs_sh_a);
        t = t ^ (t >> c_xs_sh_b);
        t = t ^ (t << c_xs_sh_c);
        return t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rand_vec_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : rand_vec_gen_if
//  Description : Request/response bundle of the random vector generator.
//  Signals     : run, mode, seed_load, seed  (requester -> generator)
//                valid, q                    (generator -> requester)
//  Modports    : master = requester, slave = generator
//  Revision    : 1.0 - initial release
// ============================================================================
interface rand_vec_gen_if
    import rand_vec_gen_pkg::*;
#(
    parameter int N_OUT = 24,
    parameter int N_LEN = c_n_len_dflt
);
    logic                   run;
    logic [1:0]             mode;
    logic                   seed_load;
    logic [31:0]            seed;
    logic                   valid;
    logic [N_OUT*N_LEN-1:0] q;

    modport master (output run, mode, seed_load, seed, input  valid, q);
    modport slave  (input  run, mode, seed_load, seed, output valid, q);
endinterface
`default_nettype wire

// File: rtl/rand_vec_gen_xorshift_lane.sv
`default_nettype none
// ============================================================================
//  Module      : xorshift_lane
//  Description : One xorshift32 generator lane with reset seed, reload port
//                and step enable. o_y is the combinational post-step value.
//  Ports       : clk, rst       - clock, synchronous active-high reset
//                i_load         - reload state from i_load_val (wins over step)
//                i_load_val     - reload value
//                i_step         - advance state to o_y
//                o_y            - next xorshift32 value of current state
//  Revision    : 1.0 - initial release
// ============================================================================
module xorshift_lane
    import rand_vec_gen_pkg::*;
#(
    parameter logic [31:0] RESET_VAL = 32'd1
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        i_load,
    input  wire logic [31:0] i_load_val,
    input  wire logic        i_step,
    output logic [31:0]      o_y
);
    logic [31:0] r_state;

    assign o_y = xs32_step(r_state);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RESET_VAL;
        end else if (i_load) begin
            r_state <= i_load_val;
        end else if (i_step) begin
            r_state <= o_y;
        end
    end
endmodule
`default_nettype wire

// File: rtl/rand_vec_gen.sv
`default_nettype none
// ============================================================================
//  Module      : rand_vec_gen
//  Description : Generates N_OUT fixed-point random samples per request with
//                LANES parallel xorshift32 lanes; signed uniform, unsigned
//                uniform or triangular distribution; run-time reseeding.
//  Ports       : clk  - rising-edge clock
//                rst  - synchronous active-high reset
//                bus  - rand_vec_gen_if.slave (run/mode/seed_load/seed in,
//                       valid/q out; slot i is q[i*N_LEN +: N_LEN])
//  Revision    : 1.0 - initial release
// ============================================================================
module rand_vec_gen
    import rand_vec_gen_pkg::*;
#(
    parameter int          N_OUT = 24,
    parameter int          N_LEN = c_n_len_dflt,
    parameter int          F_LEN = c_f_len_dflt,
    parameter int          LANES = 4,
    parameter logic [31:0] SEED  = 32'd5671
) (
    input  wire logic     clk,
    input  wire logic     rst,
    rand_vec_gen_if.slave bus
);
    localparam int c_i_len = N_LEN - F_LEN;
    localparam int c_ncyc  = (N_OUT + LANES - 1) / LANES;
    localparam int c_cw    = $clog2(c_ncyc + 1);
    localparam logic [c_cw-1:0] c_last = c_cw'(c_ncyc - 1);

    state_t                 r_state;
    logic [c_cw-1:0]        r_c;
    mode_t                  r_mode;
    logic                   r_valid;
    logic [N_OUT*N_LEN-1:0] r_q;

    logic                   w_gen_step;
    logic                   w_load;
    logic [31:0]            w_y   [LANES];
    logic [N_LEN-1:0]       w_val [LANES];

    // Lanes advance only on GEN edges that write; an abort edge leaves them.
    assign w_gen_step = (r_state == ST_GEN) && bus.run;
    assign w_load     = (r_state == ST_IDLE) && bus.seed_load;

    generate
        for (genvar k = 0; k < LANES; k++) begin : g_lane
            logic [31:0]  w_ld_seed;
            logic [N_LEN:0] w_ta;
            logic [N_LEN:0] w_tb;
            logic [N_LEN:0] w_ts;
            logic         w_unused_bits;

            assign w_ld_seed = lane_seed(bus.seed, k);

            xorshift_lane #(
                .RESET_VAL (lane_seed(SEED, k))
            ) u_lane (
                .clk        (clk),
                .rst        (rst),
                .i_load     (w_load),
                .i_load_val (w_ld_seed),
                .i_step     (w_gen_step),
                .o_y        (w_y[k])
            );

            // Triangular: mean of two signed (F_LEN+1)-bit fields taken from
            // opposite ends of the word; the extra bit keeps the sum exact.
            assign w_ta = {{c_i_len{w_y[k][F_LEN]}}, w_y[k][F_LEN:0]};
            assign w_tb = {{c_i_len{w_y[k][31]}},    w_y[k][31:31-F_LEN]};
            assign w_ts = w_ta + w_tb;

            assign w_val[k] =
                (r_mode == MODE_UU)  ? {{c_i_len{1'b0}}, w_y[k][F_LEN-1:0]} :
                (r_mode == MODE_TRI) ? w_ts[N_LEN:1] :
                                       {{c_i_len{w_y[k][F_LEN]}}, w_y[k][F_LEN-1:0]};

            // Lane bits no distribution draws from
            assign w_unused_bits = ^{w_y[k], w_ts[0]};
        end
    endgenerate

    // Slot i belongs to lane i % LANES in cycle i / LANES; slots past N_OUT
    // simply do not exist, which suppresses the trailing lane writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (w_gen_step) begin
            for (int i = 0; i < N_OUT; i++) begin
                if (r_c == c_cw'(i / LANES)) begin
                    r_q[i*N_LEN +: N_LEN] <= w_val[i % LANES];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_c     <= '0;
            r_mode  <= MODE_SU;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // A reload strobe holds off the start by one cycle
                    if (bus.run && !bus.seed_load) begin
                        r_state <= ST_GEN;
                        r_c     <= '0;
                        r_mode  <= mode_t'(bus.mode);
                    end
                end
                ST_GEN: begin
                    if (!bus.run) begin
                        r_state <= ST_IDLE;
                    end else if (r_c == c_last) begin
                        r_state <= ST_DONE;
                        r_valid <= 1'b1;
                    end else begin
                        r_c <= r_c + c_cw'(1);
                    end
                end
                ST_DONE: begin
                    if (!bus.run) begin
                        r_state <= ST_IDLE;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.valid = r_valid;
    assign bus.q     = r_q;
endmodule
`default_nettype wire
